// File: rtl/dotseq_pkg.sv
// dotseq_pkg: shared definitions for the dot-product sequencer.
//   - state_t        : sequencer FSM states
//   - *_DEF          : default widths and timing parameters
//   - MAC_LATENCY    : MAC valid_in -> valid_out delay in cycles
//   - ACC_SAT_MAX/MIN: limits the MAC saturates its accumulator to
package dotseq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_WAIT_CLR,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam int DATA_W_DEF   = 14;
  localparam int ACC_W_DEF    = 28;
  localparam int ADDR_W_DEF   = 6;
  localparam int CLR_WAIT_DEF = 6;
  localparam int TIMEOUT_DEF  = 64;

  localparam int MAC_LATENCY  = 6;

  localparam int ACC_SAT_MAX  = 134217727;
  localparam int ACC_SAT_MIN  = -134217728;

endpackage

// File: rtl/dotseq_addr_gen.sv
// dotseq_addr_gen: operand-memory read sequencer.
// On a one-cycle load pulse it issues len contiguous reads starting at
// address 0, then stops.
//   clk, reset  : clock, synchronous active-high reset
//   load        : start issuing (len must be >= 1)
//   len         : number of reads to issue, sampled with load
//   rd_en       : memory read enable (registered)
//   rd_addr     : memory read address (registered)
//   rd_q        : rd_en delayed one cycle, aligned with memory read data
//   issue_done  : high on the cycle the last read is issued
module dotseq_addr_gen
  import dotseq_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W:0]   len,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_q,
  output logic              issue_done
);

  logic              rd_en_reg;
  logic              rd_q_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [ADDR_W:0]   len_reg;

  // Address is compared one bit wider so len = 2^ADDR_W ends at the
  // all-ones address without aliasing.
  assign issue_done = rd_en_reg && ({1'b0, addr_reg} == (len_reg - 1'b1));

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_en_reg <= 1'b0;
      rd_q_reg  <= 1'b0;
      addr_reg  <= '0;
      len_reg   <= '0;
    end else begin
      rd_q_reg <= rd_en_reg;
      if (load) begin
        rd_en_reg <= 1'b1;
        addr_reg  <= '0;
        len_reg   <= len;
      end else if (rd_en_reg) begin
        addr_reg <= addr_reg + 1'b1;
        if (issue_done) begin
          rd_en_reg <= 1'b0;
        end
      end
    end
  end

  assign rd_en   = rd_en_reg;
  assign rd_addr = addr_reg;
  assign rd_q    = rd_q_reg;

endmodule

// File: rtl/dot_seq_driver.sv
// dot_seq_driver: drives one pipelined saturating MAC through a dot
// product. On start it clears the MAC, waits CLR_WAIT cycles, streams len
// operand pairs from the x/w memories, counts the MAC's valid_out pulses
// and returns the final accumulator over a valid/ready handshake.
// Optional build macro DOTSEQ_TIMEOUT_EN adds a drain watchdog that ends
// the operation with error=1 after TIMEOUT cycles in DRAIN.
// Ports:
//   clk, reset              : clock, synchronous active-high reset
//   start, len              : request and vector length (0..2^ADDR_W)
//   busy                    : not idle
//   rd_addr, rd_en          : shared x/w memory read port
//   x_data, w_data          : memory read data (one cycle after rd_en)
//   mac_a, mac_b            : MAC operands
//   mac_valid_in, mac_clear : MAC operand strobe and MAC reset
//   mac_f, mac_valid_out    : MAC accumulator and update strobe
//   result, result_valid    : captured dot product
//   result_ready            : requester accepts result
//   error                   : watchdog expired (0 without the macro)
module dot_seq_driver
  import dotseq_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ACC_W    = ACC_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int CLR_WAIT = CLR_WAIT_DEF,
  parameter int TIMEOUT  = TIMEOUT_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [ADDR_W:0]          len,
  output logic                     busy,
  output logic [ADDR_W-1:0]        rd_addr,
  output logic                     rd_en,
  input  logic signed [DATA_W-1:0] x_data,
  input  logic signed [DATA_W-1:0] w_data,
  output logic signed [DATA_W-1:0] mac_a,
  output logic signed [DATA_W-1:0] mac_b,
  output logic                     mac_valid_in,
  output logic                     mac_clear,
  input  logic signed [ACC_W-1:0]  mac_f,
  input  logic                     mac_valid_out,
  output logic signed [ACC_W-1:0]  result,
  output logic                     result_valid,
  input  logic                     result_ready,
  output logic                     error
);

  // CLR_WAIT is expected to be at least 1.
  localparam int WAIT_W = $clog2(CLR_WAIT + 1);

  state_t                   state_reg;
  logic [ADDR_W:0]          len_reg;
  logic [ADDR_W:0]          vout_cnt_reg;
  logic [ADDR_W:0]          vout_cnt_next;
  logic [WAIT_W-1:0]        wait_cnt_reg;
  logic signed [ACC_W-1:0]  last_f_reg;
  logic signed [ACC_W-1:0]  result_reg;
  logic signed [ACC_W-1:0]  f_now;
  logic                     result_valid_reg;
  logic                     issue_load;
  logic                     issue_done;
  logic                     rd_q;
  logic                     count_en;
  logic                     drain_hit;

  // MAC updates are only meaningful once operands start flowing; anything
  // seen while clearing, waiting or holding a result is stale.
  assign count_en      = mac_valid_out && (state_reg == ST_ISSUE || state_reg == ST_DRAIN);
  assign vout_cnt_next = vout_cnt_reg + (ADDR_W+1)'(count_en);
  assign drain_hit     = (state_reg == ST_DRAIN) && (vout_cnt_next == len_reg);
  // Value to return if we finish this cycle: the current MAC output when it
  // has just updated, else the most recent update seen.
  assign f_now         = count_en ? mac_f : last_f_reg;
  // Load the address generator on the last WAIT_CLR cycle so its first
  // read lines up with the first ISSUE cycle.
  assign issue_load    = (state_reg == ST_WAIT_CLR) && (wait_cnt_reg == WAIT_W'(CLR_WAIT - 1));

  dotseq_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk        (clk),
    .reset      (reset),
    .load       (issue_load),
    .len        (len_reg),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_q       (rd_q),
    .issue_done (issue_done)
  );

`ifdef DOTSEQ_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_cnt_reg;
  logic             error_reg;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= ST_IDLE;
      len_reg          <= '0;
      vout_cnt_reg     <= '0;
      wait_cnt_reg     <= '0;
      last_f_reg       <= '0;
      result_reg       <= '0;
      result_valid_reg <= 1'b0;
`ifdef DOTSEQ_TIMEOUT_EN
      tmo_cnt_reg      <= '0;
      error_reg        <= 1'b0;
`endif
    end else begin
      if (count_en) begin
        vout_cnt_reg <= vout_cnt_next;
        last_f_reg   <= mac_f;
      end
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            len_reg      <= len;
            vout_cnt_reg <= '0;
            last_f_reg   <= '0;
            if (len == '0) begin
              result_reg       <= '0;
              result_valid_reg <= 1'b1;
              state_reg        <= ST_DONE;
            end else begin
              state_reg <= ST_CLEAR;
            end
          end
        end
        ST_CLEAR: begin
          wait_cnt_reg <= '0;
          state_reg    <= ST_WAIT_CLR;
        end
        ST_WAIT_CLR: begin
          if (issue_load) begin
            state_reg <= ST_ISSUE;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
          end
        end
        ST_ISSUE: begin
`ifdef DOTSEQ_TIMEOUT_EN
          tmo_cnt_reg <= '0;
`endif
          if (issue_done) begin
            state_reg <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (drain_hit) begin
            result_reg       <= f_now;
            result_valid_reg <= 1'b1;
            state_reg        <= ST_DONE;
          end
`ifdef DOTSEQ_TIMEOUT_EN
          else if (tmo_cnt_reg == TMO_W'(TIMEOUT - 1)) begin
            result_reg       <= f_now;
            result_valid_reg <= 1'b1;
            error_reg        <= 1'b1;
            state_reg        <= ST_DONE;
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
          end
`endif
        end
        ST_DONE: begin
          if (result_ready) begin
            result_valid_reg <= 1'b0;
`ifdef DOTSEQ_TIMEOUT_EN
            error_reg        <= 1'b0;
`endif
            state_reg        <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

`ifdef DOTSEQ_TIMEOUT_EN
  assign error = error_reg;
`else
  assign error = 1'b0;
`endif

  assign busy         = (state_reg != ST_IDLE);
  assign mac_clear    = reset | (state_reg == ST_CLEAR);
  assign mac_valid_in = rd_q;
  assign mac_a        = x_data;
  assign mac_b        = w_data;
  assign result       = result_reg;
  assign result_valid = result_valid_reg;

endmodule

// File: doc/dot_seq_driver.md
# dot_seq_driver

Sequencer on the driving side of the pipelined saturating MAC. On `start`, it clears the MAC and streams `len` operand pairs from two synchronous-read operand memories into the MAC's `a/b/valid_in` port. It then counts the MAC's `valid_out` pulses, captures the final accumulated `f`, and returns it to the requester through a valid/ready result handshake. It sits between the layer controller and one MAC instance in the neuron datapath.

## Interface
- `DATA_W`, 14, operand width (signed), matches MAC `a`/`b`
- `ACC_W`, 28, accumulator width (signed), matches MAC `f`
- `ADDR_W`, 6, operand memory address width; max vector length 2^ADDR_W
- `CLR_WAIT`, 6, idle cycles after the MAC clear pulse before the first `valid_in`
- `TIMEOUT`, 64, drain watchdog limit in cycles (used only with `DOTSEQ_TIMEOUT_EN`)

Ports:
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high
- `start`  in  1  begin a dot product; sampled only in IDLE
- `len`  in  ADDR_W+1  vector length, sampled with `start`; 0 to 2^ADDR_W
- `busy`  out  1  high whenever state is not IDLE
- `rd_addr`  out  ADDR_W  shared read address for x and w memories
- `rd_en`  out  1  memory read enable
- `x_data`, `w_data`  in  DATA_W each  memory read data, valid 1 cycle after `rd_en`
- `mac_a`, `mac_b`  out  DATA_W each  operands to MAC
- `mac_valid_in`  out  1  operand strobe to MAC
- `mac_clear`  out  1  drives MAC `reset`
- `mac_f`  in  ACC_W  MAC accumulator
- `mac_valid_out`  in  1  MAC update strobe
- `result`  out  ACC_W  captured dot product
- `result_valid`  out  1  result available
- `result_ready`  in  1  requester accepts result
- `error`  out  1  watchdog expired; tied 0 without the macro

## Operation
- States: IDLE, CLEAR, WAIT_CLR, ISSUE, DRAIN, DONE.
- IDLE: on `start`, latch `len`. If `len`==0, go to DONE with `result`=0. Otherwise go to CLEAR.
- CLEAR (1 cycle): `mac_clear`=1 → WAIT_CLR.
- WAIT_CLR: stay CLR_WAIT cycles → ISSUE, with address counter =0.
- ISSUE: `rd_en`=1 and `rd_addr`=counter each cycle; counter increments. After `len` reads → DRAIN.
- Read pipeline: `rd_en` is registered into `rd_q`. `mac_valid_in`=`rd_q`. `mac_a`=`x_data` and `mac_b`=`w_data` pass through combinationally; they are don't-care when `rd_q`=0.
- DRAIN: count `mac_valid_out` pulses from the first issue onward; the count also includes pulses arriving during ISSUE. When the count reaches `len`, capture `mac_f` on that same cycle → DONE. The accumulated value is taken as-is; the MAC saturates to +134217727 / −134217728.
- DONE: `result_valid`=1 and `result` is held stable. On `result_valid & result_ready` → IDLE.
- `start` is ignored outside IDLE. `mac_valid_out` pulses in IDLE/CLEAR/WAIT_CLR/DONE are ignored.
- `mac_clear` = `reset` | (state==CLEAR), so a sequencer reset also resets the MAC.
- Reset at any time: state IDLE; `busy`, `rd_en`, `rd_q`, `mac_valid_in`, `result_valid`, `error` =0; `result`=0; `rd_addr`=0; counters =0. Any partial operation is abandoned.

## Timing
- Cycle 0: `start` sampled. Cycle 1: CLEAR. Cycles 2..CLR_WAIT+1: WAIT_CLR.
- ISSUE starts at cycle CLR_WAIT+2, and the first `mac_valid_in` follows one cycle later.
- MAC latency `valid_in`→`valid_out` is 6 cycles. Default total from `start` to `result_valid` = 1+1+CLR_WAIT+`len`+1+6 = 15+`len` cycles.
- `len`=0: `result_valid` asserts at cycle 1.
- `mac_valid_in` is contiguous for `len` cycles, with no bubbles.

## Configuration
- `DOTSEQ_TIMEOUT_EN` defined: a cycle counter runs in DRAIN. If it reaches TIMEOUT before the `valid_out` count completes, go to DONE with `error`=1 and `result`=last `mac_f` sampled on a `valid_out` (0 if none). `error` clears on the result handshake.
- Not defined: no counter is built, `error` is constant 0, and DRAIN waits indefinitely.

## Structure
- `dotseq_pkg`: state enum, default width localparams, MAC latency constant (6), saturation constants.
- Sub-module `dotseq_addr_gen`: address counter, `rd_en`/`rd_q` pipeline, issue-complete flag.

## Test plan
- `len`=3, x={1,2,3}, w={4,5,6} with the real MAC → `result`=32, exactly 3 `mac_valid_in` pulses, `result_valid` at cycle 18.
- `len`=3, x=w={8191,8191,8191} → `result`=134217727 (saturated); x={−8192×3}, w={8191×3} → −134217728.
- `len`=0 → no `mac_clear`, no reads, `result`=0, `result_valid` at cycle 1.
- `len`=4 of ones, `result_ready` held low 10 cycles in DONE, `start` pulsed meanwhile → `result`=4 stable, `start` ignored, IDLE after accept.
- Reset asserted in ISSUE after 2 reads, then `len`=2, x={−3,7}, w={5,2} → all outputs reset, `mac_clear` high during reset, second run `result`=−1.
- With `DOTSEQ_TIMEOUT_EN`: MAC model that never asserts `valid_out`, `len`=2 → `error`=1 and `result`=0 exactly TIMEOUT cycles after entering DRAIN.
